psram_responder: RTL and testbench
==================================

PSRAM_RESPONDER -- requirements
Module: psram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning word-address bits of the internal store (2^ADDR_W x 16-bit words).
REQ-002 SHALL have parameter READ_WAIT, default 6, meaning wait nibble-cycles between the last address nibble and the first read-data nibble.
REQ-003 SHALL have port mem_clk  input  1  the single clock, rising edge samples and falling edge drives.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_ce  input  1  active-low chip enable from the initiator.
REQ-006 SHALL have port mem_sio  inout  4  SPI/QPI data bus (sio[0] = SPI serial in).
REQ-007 SHALL have port qpi_mode  output  1  high while the device is in QPI mode.
REQ-008 SHALL have port cmd_err  output  1  one-cycle pulse on an unsupported command.
REQ-009 SHALL have port wr_done  output  1  one-cycle pulse when a 16-bit word is committed to the store.

Function
REQ-010 SHALL count k, the number of rising edges since mem_ce fell, with k = 0 at the first rising edge with mem_ce low.
REQ-011 SPI mode SHALL shift sio[0] MSB-first over k = 0..7 to form an 8-bit command, evaluated at k = 7.
REQ-012 SPI 0x66 SHALL set the reset-enable latch; any other complete command SHALL clear it.
REQ-013 SPI 0x99 with the latch set SHALL return the device to SPI mode and clear the latch; 0x99 without the latch SHALL be ignored.
REQ-014 SPI 0x35 SHALL set qpi_mode after mem_ce rises.
REQ-015 Any other SPI command SHALL pulse cmd_err.
REQ-016 QPI mode SHALL sample the command high nibble at k = 0 and the low nibble at k = 1.
REQ-017 QPI mode SHALL sample address nibbles at k = 2..7, forming 24 bits, MSB first.
REQ-018 The word index SHALL be address[ADDR_W-1:0], with higher bits ignored.
REQ-019 FSM states SHALL be S_SPI_CMD, S_Q_CMD, S_Q_ADDR, S_Q_WDATA, S_Q_WAIT, S_Q_RDATA, S_IGNORE; mem_ce high forces the entry state of the current mode.
REQ-020 QPI 0x38 (write) SHALL shift data nibbles at k = 8..11 MSB first, write the word at the k = 11 rising edge, and pulse wr_done in the next cycle.
REQ-021 QPI 0xEB (read) SHALL wait for READ_WAIT cycles.
REQ-022 After the wait, QPI 0xEB SHALL drive nibbles on falling edges so that they are stable at rising edges k = 8+READ_WAIT .. 11+READ_WAIT, MSB first.
REQ-023 mem_sio SHALL be driven only during read-data nibbles and high-Z at all other times, including whenever mem_ce is high.
REQ-024 Any other QPI command SHALL pulse cmd_err and enter S_IGNORE until mem_ce rises.
REQ-025 mem_ce rising mid-write before k = 11 SHALL discard the partial word, with no store update and no wr_done.
REQ-026 mem_ce rising mid-read SHALL release the bus at the next falling edge.
REQ-027 Extra rising edges after a completed single-word transfer SHALL be ignored (S_IGNORE).

Reset
REQ-028 rst_n low SHALL asynchronously set qpi_mode = 0, cmd_err = 0, wr_done = 0, k = 0, latch = 0, state S_SPI_CMD, and mem_sio high-Z.
REQ-029 Store contents SHALL NOT be cleared by reset and are undefined after power-up.
REQ-030 Reset asserted mid-transaction SHALL abort it without any store write.

Configuration
REQ-031 Macro PSRAM_RESPONDER_BURST_EN defined SHALL make writes and reads continue past the first word while mem_ce is low, with the word index incrementing modulo 2^ADDR_W (wrap from all-ones to 0) and wr_done pulsing per word.
REQ-032 Without PSRAM_RESPONDER_BURST_EN, exactly one word SHALL be transferred per transaction, as in REQ-027.

Structure
REQ-033 Shared package psram_pkg SHALL hold command constants (0x66, 0x99, 0x35, 0xEB, 0x38) and the FSM state encoding; the initiator SHALL import the same constants.
REQ-034 Sub-module psram_resp_mem SHALL be the 16-bit-wide, 2^ADDR_W-deep synchronous-write, asynchronous-read store.

Verification
REQ-035 After reset, SPI 0x66 then 0x99 then 0x35 SHALL result in qpi_mode = 1 after the third mem_ce rise, with cmd_err never pulsing.
REQ-036 QPI 0x38 at address 0x000012 with data 0xA5C3 SHALL pulse wr_done once, and a following 0xEB at 0x000012 SHALL return nibbles A,5,C,3 at k = 14..17.
REQ-037 SPI 0x99 without a prior 0x66 SHALL leave qpi_mode = 0 with no cmd_err; SPI 0x12 SHALL pulse cmd_err once.
REQ-038 QPI write of 0x1234 with mem_ce raised after k = 9 SHALL leave the old word (0xA5C3) readable, with no wr_done.
REQ-039 With BURST_EN, a write at index 0xFF of 0x1111 then 0x2222 SHALL result in index 0xFF = 0x1111 and index 0x00 = 0x2222; without BURST_EN, index 0x00 SHALL be unchanged.
REQ-040 rst_n pulsed low at k = 10 of a QPI read SHALL return mem_sio to high-Z immediately and qpi_mode to 0.

Source files
------------

// File: rtl/psram_pkg.sv
// psram_pkg: command opcodes and FSM state encoding shared by responder and initiator
package psram_pkg;
   localparam logic [7:0] CMD_RST_EN = 8'h66;
   localparam logic [7:0] CMD_RST    = 8'h99;
   localparam logic [7:0] CMD_QPI    = 8'h35;
   localparam logic [7:0] CMD_QREAD  = 8'hEB;
   localparam logic [7:0] CMD_QWRITE = 8'h38;
   typedef enum logic [2:0] {
      S_SPI_CMD, S_Q_CMD, S_Q_ADDR, S_Q_WDATA, S_Q_WAIT, S_Q_RDATA, S_IGNORE
   } state_t;
endpackage

// File: rtl/psram_resp_mem.sv
// psram_resp_mem: 16-bit word store, synchronous write and asynchronous read, no reset
module psram_resp_mem #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [15:0]       wdata,
   output logic [15:0]       rdata
);
   logic [15:0] mem [2**ADDR_W];
   // commit a word on the rising edge that carries its last nibble
   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;
   assign rdata = mem[addr];
endmodule

// File: rtl/psram_responder.sv
// psram_responder: SPI/QPI PSRAM target model; define PSRAM_RESPONDER_BURST_EN for multi-word bursts
module psram_responder
   import psram_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int READ_WAIT = 6
) (
   input  logic       mem_clk,
   input  logic       rst_n,
   input  logic       mem_ce,
   inout  wire  [3:0] mem_sio,
   output logic       qpi_mode,
   output logic       cmd_err,
   output logic       wr_done
);
`ifdef PSRAM_RESPONDER_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif
   localparam logic [7:0] WAIT_LAST = 8'(READ_WAIT - 1);
   state_t            state;
   logic [3:0]        k;
   logic              latch, qpi_pend, is_read, we, oe_q, drive;
   logic [6:0]        spi_sr;
   logic [3:0]        cmd_hi, dout_q;
   logic [ADDR_W-1:0] idx;
   logic [11:0]       wdata_sr;
   logic [1:0]        nib;
   logic [7:0]        wcnt;
   logic [15:0]       rdata;
   logic [7:0]        spi_cmd, q_cmd;
   assign spi_cmd = {spi_sr, mem_sio[0]};
   assign q_cmd   = {cmd_hi, mem_sio};
   assign we      = (state == S_Q_WDATA) && !mem_ce && (nib == 2'd3);
   assign drive   = oe_q & ~mem_ce;
   assign mem_sio = drive ? dout_q : 4'bz;
   psram_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
      .clk(mem_clk), .we(we), .addr(idx), .wdata({wdata_sr, mem_sio}), .rdata(rdata)
   );
   // protocol FSM: samples the bus on rising edges, restarts whenever mem_ce is high
   always_ff @(posedge mem_clk or negedge rst_n)
      if (!rst_n) begin
         state    <= S_SPI_CMD;
         k        <= '0;
         latch    <= 1'b0;
         qpi_pend <= 1'b0;
         qpi_mode <= 1'b0;
         cmd_err  <= 1'b0;
         wr_done  <= 1'b0;
         is_read  <= 1'b0;
         spi_sr   <= '0;
         cmd_hi   <= '0;
         idx      <= '0;
         wdata_sr <= '0;
         nib      <= '0;
         wcnt     <= '0;
      end else begin
         cmd_err <= 1'b0;
         wr_done <= we;
         if (mem_ce) begin
            k        <= '0;
            nib      <= '0;
            wcnt     <= '0;
            qpi_mode <= qpi_mode | qpi_pend;
            qpi_pend <= 1'b0;
            state    <= (qpi_mode | qpi_pend) ? S_Q_CMD : S_SPI_CMD;
         end else begin
            k <= (k == 4'hF) ? k : k + 4'd1;
            case (state)
               S_SPI_CMD: begin
                  spi_sr <= spi_cmd[6:0];
                  if (k == 4'd7) begin
                     state <= S_IGNORE;
                     latch <= (spi_cmd == CMD_RST_EN);
                     if (spi_cmd == CMD_RST && latch) qpi_mode <= 1'b0;
                     else if (spi_cmd == CMD_QPI) qpi_pend <= 1'b1;
                     else if (spi_cmd != CMD_RST_EN && spi_cmd != CMD_RST) cmd_err <= 1'b1;
                  end
               end
               S_Q_CMD: begin
                  cmd_hi <= mem_sio;
                  if (k == 4'd1) begin
                     is_read <= (q_cmd == CMD_QREAD);
                     if (q_cmd == CMD_QREAD || q_cmd == CMD_QWRITE) state <= S_Q_ADDR;
                     else begin
                        cmd_err <= 1'b1;
                        state   <= S_IGNORE;
                     end
                  end
               end
               S_Q_ADDR: begin
                  idx <= ADDR_W'({idx, mem_sio});
                  if (k == 4'd7)
                     state <= !is_read ? S_Q_WDATA : (READ_WAIT == 0 ? S_Q_RDATA : S_Q_WAIT);
               end
               S_Q_WDATA: begin
                  wdata_sr <= {wdata_sr[7:0], mem_sio};
                  nib      <= nib + 2'd1;
                  if (nib == 2'd3) begin
                     idx   <= idx + ADDR_W'(1);
                     state <= BURST ? S_Q_WDATA : S_IGNORE;
                  end
               end
               S_Q_WAIT: begin
                  wcnt <= wcnt + 8'd1;
                  if (wcnt == WAIT_LAST) state <= S_Q_RDATA;
               end
               S_Q_RDATA: begin
                  nib <= nib + 2'd1;
                  if (nib == 2'd3) begin
                     idx   <= idx + ADDR_W'(1);
                     state <= BURST ? S_Q_RDATA : S_IGNORE;
                  end
               end
               default: ;
            endcase
         end
      end
   // read nibbles launch on falling edges so they are stable at the next rising edge
   always_ff @(negedge mem_clk or negedge rst_n)
      if (!rst_n) begin
         oe_q   <= 1'b0;
         dout_q <= '0;
      end else begin
         oe_q   <= (state == S_Q_RDATA) && !mem_ce;
         dout_q <= nib == 2'd0 ? rdata[15:12] : nib == 2'd1 ? rdata[11:8] :
                   nib == 2'd2 ? rdata[7:4] : rdata[3:0];
      end
endmodule

// File: tb/tb_psram_responder.sv
// tb_psram_responder: directed SPI/QPI transactions with a queue-based scoreboard and event monitor
module tb_psram_responder;
   localparam int RW = 6;
   logic       mem_clk = 1'b0;
   logic       rst_n   = 1'b1;
   logic       mem_ce  = 1'b1;
   logic       tb_oe   = 1'b0;
   logic [3:0] tb_d    = 4'h0;
   wire  [3:0] mem_sio;
   logic       qpi_mode, cmd_err, wr_done;
   int         checks = 0, errors = 0;
   int         exp_wr[$], exp_err[$], rd_k[$];
   logic [3:0] rd_v[$];

   assign mem_sio = tb_oe ? tb_d : 4'bz;

   // free-running clock
   always #5 mem_clk = ~mem_clk;

   psram_responder #(.ADDR_W(8), .READ_WAIT(RW)) dut (
      .mem_clk(mem_clk), .rst_n(rst_n), .mem_ce(mem_ce), .mem_sio(mem_sio),
      .qpi_mode(qpi_mode), .cmd_err(cmd_err), .wr_done(wr_done)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexp(input string name, input int ke);
      checks++;
      errors++;
      $display("FAIL unexpected %s at k=%0d: got event expected none", name, ke);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge mem_clk);
   endtask

   task automatic begin_tx();
      @(negedge mem_clk);
      mem_ce = 1'b0;
      tb_oe  = 1'b1;
   endtask

   task automatic put(input logic [3:0] v);
      tb_d = v;
      @(negedge mem_clk);
   endtask

   task automatic end_tx();
      mem_ce = 1'b1;
      tb_oe  = 1'b0;
      idle(2);
   endtask

   task automatic spi(input logic [7:0] c);
      begin_tx();
      for (int i = 7; i >= 0; i--) put({3'b000, c[i]});
      end_tx();
   endtask

   task automatic hdr(input logic [7:0] c, input logic [23:0] a);
      begin_tx();
      put(c[7:4]);
      put(c[3:0]);
      for (int i = 5; i >= 0; i--) put(a[4*i +: 4]);
   endtask

   task automatic qwrite(input logic [23:0] a, input logic [31:0] d, input int n);
      hdr(8'h38, a);
      for (int i = 0; i < n; i++) put(d[28-4*i +: 4]);
      end_tx();
   endtask

   task automatic qread(input logic [23:0] a, input logic [15:0] w);
      for (int j = 0; j < 4; j++) begin
         rd_k.push_back(8 + RW + j);
         rd_v.push_back(w[12-4*j +: 4]);
      end
      hdr(8'hEB, a);
      tb_oe = 1'b0;
      idle(RW + 4);
      end_tx();
   endtask

   // monitor: tracks k per rising edge and pops the scoreboard on every DUT event
   initial begin : monitor
      int kc, ke;
      kc = 0;
      forever begin
         @(posedge mem_clk);
         if (!rst_n || mem_ce) begin
            kc = 0;
            ke = -1;
         end else begin
            ke = kc;
            kc++;
         end
         #1;
         if (wr_done) begin
            if (exp_wr.size() == 0) unexp("wr_done", ke);
            else chk("wr_done k", ke, exp_wr.pop_front());
         end
         if (cmd_err) begin
            if (exp_err.size() == 0) unexp("cmd_err", ke);
            else chk("cmd_err k", ke, exp_err.pop_front());
         end
         if (dut.drive) begin
            if (rd_k.size() == 0) unexp("bus drive", ke);
            else begin
               chk("read k", ke, rd_k.pop_front());
               chk("read nibble", int'(mem_sio), int'(rd_v.pop_front()));
            end
         end
      end
   end

   // watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   // directed stimulus
   initial begin
      #2 rst_n = 1'b0;
      idle(3);
      chk("reset qpi_mode", int'(qpi_mode), 0);
      chk("reset cmd_err", int'(cmd_err), 0);
      chk("reset wr_done", int'(wr_done), 0);
      chk("reset bus release", int'(dut.drive), 0);
      rst_n = 1'b1;
      idle(2);
      spi(8'h99);
      chk("0x99 without latch", int'(qpi_mode), 0);
      exp_err.push_back(7);
      spi(8'h12);
      chk("0x12 stays spi", int'(qpi_mode), 0);
      spi(8'h66);
      spi(8'h99);
      spi(8'h35);
      chk("enter qpi", int'(qpi_mode), 1);
      exp_wr.push_back(11);
      qwrite(24'h000012, 32'hA5C3_0000, 4);
      qread(24'h000012, 16'hA5C3);
      qwrite(24'h000012, 32'h1234_0000, 2);
      qread(24'h000012, 16'hA5C3);
      exp_err.push_back(1);
      begin_tx();
      put(4'h1);
      put(4'h2);
      put(4'h0);
      put(4'h0);
      end_tx();
      exp_wr.push_back(11);
      qwrite(24'h000100, 32'hBEEF_0000, 4);
      exp_wr.push_back(11);
`ifdef PSRAM_RESPONDER_BURST_EN
      exp_wr.push_back(15);
`endif
      qwrite(24'h0000FF, 32'h1111_2222, 8);
      qread(24'h0000FF, 16'h1111);
`ifdef PSRAM_RESPONDER_BURST_EN
      qread(24'h000000, 16'h2222);
`else
      qread(24'h000000, 16'hBEEF);
`endif
      hdr(8'hEB, 24'h000012);
      tb_oe = 1'b0;
      repeat (3) @(posedge mem_clk);
      #2 rst_n = 1'b0;
      #1;
      chk("reset mid-read bus", int'(dut.drive), 0);
      chk("reset mid-read qpi_mode", int'(qpi_mode), 0);
      @(negedge mem_clk);
      mem_ce = 1'b1;
      idle(2);
      rst_n = 1'b1;
      idle(3);
      chk("post-reset qpi_mode", int'(qpi_mode), 0);
      chk("pending wr_done", exp_wr.size(), 0);
      chk("pending cmd_err", exp_err.size(), 0);
      chk("pending read nibbles", rd_k.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
